klotski_solve_sequencer: RTL

- Top-level step scheduler for the sliding-puzzle solver.
- Places tiles 1..N_TILES at their home cells, in order. For each single-cell tile step it first calls the zero-routing engine to park the blank at the tile's next cell. It then issues the tile move to the motor path and waits for the motor to acknowledge.
- Owns the board copy, the locked-cell mask and the step counter. Sits between the camera/board-capture logic and the motor controller.

---
 rtl/klotski_solve_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/klotski_solve_sequencer.sv
// Step scheduler for the sliding-puzzle solver: places tiles 1..N_TILES at
// their home cells by parking the blank with the zero-routing engine and
// then commanding a single-cell tile move on the motor path.
module klotski_solve_sequencer #(
  parameter int unsigned N_TILES   = 3,
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [63:0] i_klotski,
  output logic        o_mz_start,
  output logic [63:0] o_mz_klotski,
  output logic [15:0] o_mz_mask,
  output logic [3:0]  o_mz_target,
  output logic [3:0]  o_mz_num_pos,
  output logic        o_mz_flag,
  input  logic        i_mz_finished,
  input  logic [63:0] i_mz_klotski,
  output logic        o_mv_en,
  output logic [3:0]  o_mv_start_block,
  output logic [3:0]  o_mv_end_block,
  input  logic        i_mv_done,
  output logic [3:0]  o_tile,
  output logic [7:0]  o_step_count,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned N_CELLS = 16;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOCATE   = 4'd1;
  localparam logic [3:0] S_PLAN     = 4'd2;
  localparam logic [3:0] S_MZ_START = 4'd3;
  localparam logic [3:0] S_MZ_WAIT  = 4'd4;
  localparam logic [3:0] S_MV_ISSUE = 4'd5;
  localparam logic [3:0] S_MV_WAIT  = 4'd6;
  localparam logic [3:0] S_ADVANCE  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_ERROR    = 4'd9;

  logic [3:0]  state_q, state_d;
  logic [63:0] board_q, board_d;
  logic [15:0] lock_q, lock_d;
  logic [3:0]  tile_q, tile_d;
  logic [7:0]  count_q, count_d;
  logic [3:0]  pos_q, pos_d;
  logic [3:0]  tgt_q, tgt_d;

  logic        loc_found;
  logic [3:0]  loc_pos;
  logic [3:0]  home;
  logic [3:0]  nxt;

  assign home         = tile_q - 4'd1;
  assign o_mz_flag    = 1'b0;
  assign o_step_count = count_q;

  // Find the cell holding the current tile; the highest matching cell wins.
  always_comb begin
    loc_found = 1'b0;
    loc_pos   = 4'd0;
    for (int k = 0; k < N_CELLS; k++) begin
      if (board_q[k*4 +: 4] == tile_q) begin
        loc_found = 1'b1;
        loc_pos   = 4'(k);
      end
    end
  end

  // Next cell one step toward home: fix the column first, then the row.
  always_comb begin
    nxt = pos_q;
    if (pos_q[1:0] != home[1:0]) begin
      nxt = (home[1:0] > pos_q[1:0]) ? pos_q + 4'd1 : pos_q - 4'd1;
    end else begin
      nxt = (home[3:2] > pos_q[3:2]) ? pos_q + 4'd4 : pos_q - 4'd4;
    end
  end

  // State and datapath register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      board_q <= '0;
      lock_q  <= '0;
      tile_q  <= 4'd1;
      count_q <= '0;
      pos_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      lock_q  <= lock_d;
      tile_q  <= tile_d;
      count_q <= count_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    lock_d  = lock_q;
    tile_d  = tile_q;
    count_d = count_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          board_d = i_klotski;
          lock_d  = '0;
          tile_d  = 4'd1;
          count_d = '0;
          state_d = S_LOCATE;
        end
      end
      S_LOCATE: begin
        if (!loc_found) begin
          state_d = S_ERROR;
        end else begin
          pos_d   = loc_pos;
          state_d = (loc_pos == home) ? S_ADVANCE : S_PLAN;
        end
      end
      S_PLAN: begin
        if (lock_q[nxt] || (count_q == 8'(MAX_STEPS))) begin
          state_d = S_ERROR;
        end else begin
          tgt_d   = nxt;
          state_d = S_MZ_START;
        end
      end
      S_MZ_START: state_d = S_MZ_WAIT;
      S_MZ_WAIT: begin
        if (i_mz_finished) begin
          board_d = i_mz_klotski;
          state_d = (i_mz_klotski[{tgt_q, 2'b00} +: 4] != 4'd0) ? S_ERROR : S_MV_ISSUE;
        end
      end
      S_MV_ISSUE: state_d = S_MV_WAIT;
      S_MV_WAIT: begin
        if (i_mv_done) begin
          board_d[{tgt_q, 2'b00} +: 4] = tile_q;
          board_d[{pos_q, 2'b00} +: 4] = 4'd0;
          count_d = count_q + 8'd1;
          state_d = S_LOCATE;
        end
      end
      S_ADVANCE: begin
        lock_d = lock_q | (16'd1 << home);
        if (tile_q == 4'(N_TILES)) begin
          state_d = S_DONE;
        end else begin
          tile_d  = tile_q + 4'd1;
          state_d = S_LOCATE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered handshake outputs; request fields hold until the next request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mz_start       <= 1'b0;
      o_mz_klotski     <= '0;
      o_mz_mask        <= '0;
      o_mz_target      <= '0;
      o_mz_num_pos     <= '0;
      o_mv_en          <= 1'b0;
      o_mv_start_block <= '0;
      o_mv_end_block   <= '0;
      o_tile           <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      o_mz_start <= (state_d == S_MZ_START);
      o_mv_en    <= (state_d == S_MV_ISSUE);
      o_busy     <= (state_d != S_IDLE);
      o_done     <= (state_d == S_DONE);
      o_error    <= (state_d == S_ERROR);
      if (state_d != S_IDLE) begin
        o_tile <= tile_d;
      end
      if ((state_q == S_PLAN) && (state_d == S_MZ_START)) begin
        o_mz_klotski <= board_q;
        o_mz_mask    <= lock_q | (16'd1 << pos_q);
        o_mz_target  <= nxt;
        o_mz_num_pos <= pos_q;
      end
      if ((state_q == S_MZ_WAIT) && (state_d == S_MV_ISSUE)) begin
        o_mv_start_block <= pos_q;
        o_mv_end_block   <= tgt_q;
      end
    end
  end

endmodule
